mii_frame_checker: RTL

//  Receive-side counterpart of the MII frame generator: parses the 8-bit data + ctrl byte stream into frames.

---
 rtl/mii_frame_checker.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/mii_frame_checker.sv
// Receive-side MII frame checker: parses START/preamble/SFD/header/payload/FCS/TERMINATE,
// streams the payload with the FCS stripped, and flags each frame good or bad with counters.
module mii_frame_checker #(
    parameter int          PREAMBLE_CYCLES = 6,
    parameter int          DST_ADDR_CYCLES = 6,
    parameter int          SRC_ADDR_CYCLES = 6,
    parameter int          LEN_TYP_CYCLES  = 2,
    parameter int          MIN_DATA_CYCLES = 46,
    parameter int          MAX_DATA_CYCLES = 1500,
    parameter int          FCS_CYCLES      = 4,
    parameter logic [7:0]  IDLE_CODE       = 8'h07,
    parameter logic [7:0]  START_CODE      = 8'hFB,
    parameter logic [7:0]  TERMINATE_CODE  = 8'hFD,
    parameter logic [7:0]  PREAMBLE_CODE   = 8'h55,
    parameter logic [7:0]  SFD_CODE        = 8'hD5,
    parameter logic [7:0]  DST_ADDR_CODE   = 8'h01,
    parameter logic [7:0]  SRC_ADDR_CODE   = 8'h02,
    parameter logic [7:0]  LEN_TYP_CODE    = 8'h03,
    parameter logic [7:0]  FCS_CODE        = 8'h04
) (
    input  logic        clk,
    input  logic        i_rst,
    input  logic [7:0]  i_rx_data,
    input  logic        i_rx_ctrl,
    output logic [7:0]  o_data,
    output logic        o_data_valid,
    output logic        o_sof,
    output logic        o_eof,
    output logic        o_frame_ok,
    output logic        o_frame_err,
    output logic [3:0]  o_err_code,
    output logic [15:0] o_frame_count,
    output logic [15:0] o_err_count,
    output logic [2:0]  o_state
);

    typedef enum logic [2:0] {
        S_IDLE, S_PREAMBLE, S_SFD, S_DST, S_SRC, S_LEN, S_PAYLOAD, S_DROP
    } state_t;

    localparam logic [3:0]  ERR_PRE   = 4'd1;
    localparam logic [3:0]  ERR_HDR   = 4'd2;
    localparam logic [3:0]  ERR_CTRL  = 4'd3;
    localparam logic [3:0]  ERR_FCS   = 4'd4;
    localparam logic [3:0]  ERR_RUNT  = 4'd5;
    localparam logic [3:0]  ERR_OVER  = 4'd6;
    localparam logic [11:0] LP_FCS    = 12'(FCS_CYCLES);
    localparam logic [11:0] LP_MINEND = 12'(FCS_CYCLES + MIN_DATA_CYCLES);
    localparam logic [11:0] LP_OVER   = 12'(MAX_DATA_CYCLES + FCS_CYCLES);

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic [11:0] r_pcnt;
    logic [7:0]  r_sr [FCS_CYCLES];

    logic        w_err;
    logic        w_ok;
    logic [3:0]  w_code;
    logic        w_fcs_ok;
    logic [7:0]  w_expect;
    logic [3:0]  w_last;
    state_t      w_next_field;

    assign o_state = r_state;

    // Expected byte, field length and successor for the fixed-content header states.
    always_comb begin
        w_expect     = PREAMBLE_CODE;
        w_last       = 4'(PREAMBLE_CYCLES - 1);
        w_next_field = S_SFD;
        case (r_state)
            S_SFD: begin w_expect = SFD_CODE; w_last = 4'd0; w_next_field = S_DST; end
            S_DST: begin w_expect = DST_ADDR_CODE; w_last = 4'(DST_ADDR_CYCLES - 1); w_next_field = S_SRC; end
            S_SRC: begin w_expect = SRC_ADDR_CODE; w_last = 4'(SRC_ADDR_CYCLES - 1); w_next_field = S_LEN; end
            S_LEN: begin w_expect = LEN_TYP_CODE; w_last = 4'(LEN_TYP_CYCLES - 1); w_next_field = S_PAYLOAD; end
            default: ;
        endcase
    end

    always_comb begin
        w_fcs_ok = 1'b1;
        for (int i = 0; i < FCS_CYCLES; i++) begin
            if (r_sr[i] != FCS_CODE) w_fcs_ok = 1'b0;
        end
    end

    always_comb begin
        w_err  = 1'b0;
        w_ok   = 1'b0;
        w_code = 4'd0;
        case (r_state)
            S_PREAMBLE, S_SFD, S_DST, S_SRC, S_LEN: begin
                if (i_rx_ctrl) begin
                    w_err  = 1'b1;
                    w_code = ERR_CTRL;
                end else if (i_rx_data != w_expect) begin
                    w_err  = 1'b1;
                    w_code = (r_state == S_PREAMBLE || r_state == S_SFD) ? ERR_PRE : ERR_HDR;
                end
            end
            S_PAYLOAD: begin
                if (i_rx_ctrl && i_rx_data == TERMINATE_CODE) begin
                    // Register now holds the FCS; pcnt includes those FCS bytes.
                    if (r_pcnt < LP_MINEND) begin
                        w_err  = 1'b1;
                        w_code = ERR_RUNT;
                    end else if (!w_fcs_ok) begin
                        w_err  = 1'b1;
                        w_code = ERR_FCS;
                    end else begin
                        w_ok = 1'b1;
                    end
                end else if (i_rx_ctrl) begin
                    w_err  = 1'b1;
                    w_code = ERR_CTRL;
                end else if (r_pcnt == LP_OVER) begin
                    w_err  = 1'b1;
                    w_code = ERR_OVER;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_state       <= S_IDLE;
            r_cnt         <= 4'd0;
            r_pcnt        <= 12'd0;
            for (int i = 0; i < FCS_CYCLES; i++) r_sr[i] <= 8'd0;
            o_data        <= 8'd0;
            o_data_valid  <= 1'b0;
            o_sof         <= 1'b0;
            o_eof         <= 1'b0;
            o_frame_ok    <= 1'b0;
            o_frame_err   <= 1'b0;
            o_err_code    <= 4'd0;
            o_frame_count <= 16'd0;
            o_err_count   <= 16'd0;
        end else begin
            o_data_valid <= 1'b0;
            o_sof        <= 1'b0;
            o_eof        <= 1'b0;
            o_frame_ok   <= 1'b0;
            o_frame_err  <= 1'b0;
            if (w_err) begin
                o_frame_err <= 1'b1;
                o_eof       <= 1'b1;
                o_err_code  <= w_code;
                if (o_err_count != 16'hFFFF) o_err_count <= o_err_count + 16'd1;
                r_state     <= S_DROP;
            end else if (w_ok) begin
                o_frame_ok  <= 1'b1;
                o_eof       <= 1'b1;
                if (o_frame_count != 16'hFFFF) o_frame_count <= o_frame_count + 16'd1;
                r_state     <= S_IDLE;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (i_rx_ctrl && i_rx_data == START_CODE) begin
                            r_state <= S_PREAMBLE;
                            r_cnt   <= 4'd0;
                        end
                    end
                    S_PREAMBLE, S_SFD, S_DST, S_SRC, S_LEN: begin
                        if (r_cnt == w_last) begin
                            r_state <= w_next_field;
                            r_cnt   <= 4'd0;
                            r_pcnt  <= 12'd0;
                        end else begin
                            r_cnt <= r_cnt + 4'd1;
                        end
                    end
                    S_PAYLOAD: begin
                        r_sr[0] <= i_rx_data;
                        for (int i = 1; i < FCS_CYCLES; i++) r_sr[i] <= r_sr[i-1];
                        if (r_pcnt != 12'hFFF) r_pcnt <= r_pcnt + 12'd1;
                        if (r_pcnt >= LP_FCS) begin
                            o_data       <= r_sr[FCS_CYCLES-1];
                            o_data_valid <= 1'b1;
                            o_sof        <= (r_pcnt == LP_FCS);
                        end
                    end
                    S_DROP: begin
                        if (i_rx_ctrl && (i_rx_data == IDLE_CODE || i_rx_data == TERMINATE_CODE))
                            r_state <= S_IDLE;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

endmodule
